// File: rtl/mips_pkg.sv
// Shared MINI-MIPS constants and encodings.
// Used by the HI/LO multiply/divide unit.
package mips_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_signfix.sv
// Conditional two's-complement negate.
// Gives |x| on operands and restores sign on results.
module md_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  always_comb begin
    res_o = val_i;
    if (neg_i) res_o = ~val_i + W'(1);
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative mult/div engine owning HI/LO.
// 32 shift-add or restoring steps, then one sign-fix cycle.
module hilo_muldiv #(
  parameter int XLEN  = mips_pkg::XLEN,
  parameter int CNT_W = mips_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mthi,
  input  logic            mtlo,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  import mips_pkg::*;

  localparam int DW = 2 * XLEN;

  md_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic [XLEN-1:0]  araw_q, araw_d;
  logic [XLEN-1:0]  mc_q, mc_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic             done_q, done_d;

  logic is_div, is_sgn, sgn_a, sgn_b;
  logic [XLEN-1:0] abs_a, abs_b;

  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign is_sgn = (op == MD_MULT) || (op == MD_DIV);
  assign sgn_a  = is_sgn & a[XLEN-1];
  assign sgn_b  = is_sgn & b[XLEN-1];

  md_signfix #(.W(XLEN)) u_abs_a (
    .val_i(a), .neg_i(sgn_a), .res_o(abs_a)
  );

  md_signfix #(.W(XLEN)) u_abs_b (
    .val_i(b), .neg_i(sgn_b), .res_o(abs_b)
  );

  // One iteration of each engine
  logic [XLEN:0]   mul_sum;
  logic [DW-1:0]   mul_nxt;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic [DW-1:0]   div_nxt;

  always_comb begin
    mul_sum = {1'b0, acc_q[DW-1:XLEN]} + {1'b0, mc_q};
    if (acc_q[0]) mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
    else          mul_nxt = {1'b0, acc_q[DW-1:1]};
    rem_sh = {acc_q[DW-1:XLEN], acc_q[XLEN-1]};
    trial  = rem_sh - {1'b0, mc_q};
    if (trial[XLEN])
      div_nxt = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else
      div_nxt = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  logic [DW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic [XLEN-1:0] res_hi, res_lo;

  md_signfix #(.W(DW)) u_fix_prod (
    .val_i(acc_q), .neg_i(sa_q ^ sb_q), .res_o(prod_fix)
  );

  md_signfix #(.W(XLEN)) u_fix_quo (
    .val_i(acc_q[XLEN-1:0]), .neg_i(sa_q ^ sb_q), .res_o(quo_fix)
  );

  md_signfix #(.W(XLEN)) u_fix_rem (
    .val_i(acc_q[DW-1:XLEN]), .neg_i(sa_q), .res_o(rem_fix)
  );

  always_comb begin
    res_hi = prod_fix[DW-1:XLEN];
    res_lo = prod_fix[XLEN-1:0];
    if (div_q && dz_q) begin
      res_hi = araw_q;
      res_lo = '1;
    end else if (div_q) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      araw_q  <= '0;
      mc_q    <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      araw_q  <= araw_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    dz_d   = dz_q;
    araw_d = araw_q;
    mc_d   = mc_q;
    acc_d  = acc_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d  = CNT_W'(XLEN - 1);
          div_d  = is_div;
          sa_d   = sgn_a;
          sb_d   = sgn_b;
          dz_d   = is_div && (b == '0);
          araw_d = a;
          mc_d   = is_div ? abs_b : abs_a;
          acc_d  = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
        end else begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end
      S_RUN: begin
        acc_d = div_q ? div_nxt : mul_nxt;
        cnt_d = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        hi_d   = res_hi;
        lo_d   = res_lo;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv with a cycle-level
// arithmetic reference model and literal result checks.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int cmp_n = 0;
  int err_n = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic logic [63:0] mdl(
    input logic [1:0] o, input logic [31:0] x, input logic [31:0] y
  );
    longint sx, sy, q, m;
    longint unsigned ux, uy, uq, um;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r = '0;
    case (o)
      2'b00: r = 64'(sx * sy);
      2'b01: r = 64'(ux * uy);
      default: begin
        if (y == 32'd0) begin
          r = {x, 32'hFFFFFFFF};
        end else if (o == 2'b10) begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end else begin
          uq = ux / uy;
          um = ux % uy;
          r = {um[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Reference: an accepted start yields a result 33 edges later
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;
  bit          m_done;

  always @(posedge clk) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_pend = mdl(op, a, b);
        m_left = 33;
      end else begin
        if (mthi) m_hi = a;
        if (mtlo) m_lo = a;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 64'(busy), 64'(m_left > 0));
      check("cyc_done", 64'(done), 64'(m_done));
      check("cyc_hi", 64'(hi), 64'(m_hi));
      check("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic th,
                       input logic tl);
    start = 1'b1; op = o; a = x; b = y; mthi = th; mtlo = tl;
    @(posedge clk); #2;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    check({nm, "_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(o, x, y, 1'b0, 1'b0);
    wait_done(nm, n);
    check({nm, "_lat"}, 64'(n), 64'd34);
    check({nm, "_hi"}, 64'(hi), 64'(eh));
    check({nm, "_lo"}, 64'(lo), 64'(el));
    @(posedge clk); #2;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; op = 2'b00;
    a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);

    // Reset mid-operation discards everything
    a = 32'h11111111; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #2;
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both", {hi, lo}, {32'h11111111, 32'h11111111});
    issue(2'b00, 32'd5, 32'd7, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_hilo", {hi, lo}, 64'd0);
    repeat (40) @(posedge clk);
    #2;

    run_op("mult", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu", 2'b01, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB);
    run_op("div", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divz", 2'b11, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    run_op("divzs", 2'b10, 32'h80000005, 32'd0, 32'h80000005, 32'hFFFFFFFF);
    run_op("divov", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run_op("multneg", 2'b00, 32'h80000000, 32'hFFFFFFFF,
           32'h00000000, 32'h80000000);
    run_op("multbig", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001);
    run_op("divneg", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);

    // Inputs while busy are ignored
    issue(2'b00, 32'd3, 32'd5, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    start = 1'b1; op = 2'b11; a = 32'hDEADBEEF; b = 32'd1; mthi = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; mthi = 1'b0;
    wait_done("ign", n);
    check("ign_lat", 64'(n), 64'd28);
    check("ign_res", {hi, lo}, {32'd0, 32'd15});
    @(posedge clk); #2;
    check("ign_idle", 64'(busy), 64'd0);
    a = 32'hDEADBEEF; mthi = 1'b1;
    @(posedge clk); #2;
    mthi = 1'b0;
    check("mthi_idle", 64'(hi), 64'hDEADBEEF);

    // start wins over mtlo on the same edge
    issue(2'b11, 32'd100, 32'd7, 1'b0, 1'b1);
    check("stlo_lo", 64'(lo), 64'd15);
    wait_done("stlo", n);
    check("stlo_res", {hi, lo}, {32'd2, 32'd14});

    // Start in the done cycle is accepted
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd7;
    @(posedge clk); #2;
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done("b2b", n);
    check("b2b_lat", 64'(n), 64'd34);
    check("b2b_res", {hi, lo}, {32'd0, 32'd35});
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair for the MINI-MIPS datapath.
- It sits beside the ALU in the execute stage and takes the same register-file operands (a, b).
- It produces the hi/lo values that the ALU's mfhi/mflo paths read.
- It replaces the single-cycle combinational product with a 32-iteration shift/add and restoring-divide engine, and gives the control unit a busy/done handshake for stalls.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width, equal to log2(XLEN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only when busy=0.
- op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
- a  input  XLEN  rs operand (multiplicand / dividend).
- b  input  XLEN  rt operand (multiplier / divisor).
- mthi  input  1  write a into HI.
- mtlo  input  1  write a into LO.
- busy  output  1  high while an operation is in progress; control unit stalls mfhi/mflo/mult/div.
- done  output  1  one-cycle pulse in the first cycle that new hi/lo are visible.
- hi  output  XLEN  HI register (product[63:32] / remainder).
- lo  output  XLEN  LO register (product[31:0] / quotient).

Behaviour:
- Reset: a synchronous reset on a clk edge with rst=1 forces the following.
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0; the counter and internal accumulators clear.
  - Reset overrides any operation in progress. A partial result is discarded and hi/lo do not keep pre-reset values.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at an edge latches op, the sign flags and |a|, |b|. Signed ops use magnitudes; unsigned ops take the raw values.
  - The counter loads to XLEN-1, state goes to RUN, and busy=1 from the next cycle.
  - If start=1 and mthi/mtlo are asserted on the same edge, start wins and the mt writes are dropped.
  - With start=0, mthi loads hi<=a and mtlo loads lo<=a on that edge. Both may be asserted together.
- RUN, multiply: one shift-add step per cycle on a 64-bit accumulator. If the current multiplier LSB is 1, add the multiplicand to the upper half, then shift right 1.
- RUN, divide: one restoring step per cycle. Shift the {rem, quo} pair left 1, trial-subtract the divisor from rem, keep the result and set the quo bit if it is non-negative.
- RUN to FIX: the counter decrements each cycle; at counter==0 the state goes to FIX. RUN lasts exactly XLEN cycles.
- FIX (one cycle): apply sign fixup and write hi/lo on the exiting edge.
  - mult: two's-complement negate the 64-bit product if sign_a^sign_b.
  - div: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Then go to IDLE with done=1 and busy=0 in that cycle.
- Latency: start sampled at edge N gives busy=1 in cycles N+1..N+33, hi/lo updated at edge N+34, and done=1 in cycle N+34 only.
  - Back-to-back: start may be asserted in the done cycle and is accepted.
- Ignored inputs: start, mthi and mtlo while busy=1 are ignored with no queueing. hi/lo hold their old values throughout RUN/FIX.
- Divide by zero (b==0, div or divu): no trap. Result is hi=a (original a, unsigned view), lo=32'hFFFFFFFF.
  - Detected at start; the operation still takes the full latency so timing is data-independent.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Widths:
  - The product accumulator is 2*XLEN.
  - Divide uses an XLEN+1 bit trial subtract to keep the borrow.
  - Magnitude of 0x80000000 is 0x80000000 in unsigned XLEN.

Decomposition:
- Shared package mips_pkg:
  - Op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - State encoding (IDLE/RUN/FIX).
  - XLEN constant.
- One natural sub-module, md_signfix: combinational abs on input and conditional negate on output. It is reused for the operand and result paths.
- The FSM, counter and datapath stay in hilo_muldiv.

Test Plan:
- Reset mid-RUN: start mult a=5, b=7, assert rst at cycle 10 -> next cycle busy=0, hi=0, lo=0, done never pulses.
- Signed mult: a=0xFFFFFFFD (-3), b=7 -> done at start+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - Same operands with multu -> hi=0x00000006, lo=0xFFFFFFEB.
- Signed div: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu a=100, b=7 -> lo=14, hi=2.
- Corner divides:
  - divu a=0x12345678, b=0 -> hi=0x12345678, lo=0xFFFFFFFF, latency unchanged.
  - div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake:
  - start pulses while busy are ignored; hi/lo stay stable during RUN.
  - mthi a=0xDEADBEEF while busy has no effect; when idle it sets hi=0xDEADBEEF next cycle.
  - start+mtlo on the same edge: mtlo is dropped.
  - start in the done cycle is accepted, giving busy=1 the next cycle.
